multi_operand_proc: RTL
=======================

Name: multi_operand_proc

Overview:
Parametrised operand-reduction processor. Holds NUM_IN operand registers of WIDTH bits. Operands are loaded one at a time by index. On a start pulse, the block reduces all operands to one result, one operand per cycle, using a selectable operation. The proc/rdy pair reports status, and the block feeds the 7-segment/status outputs of the top level.

Parameters:
WIDTH, 4, bit width of each operand and of the result
NUM_IN, 4, number of operand registers (>=1); localparam IDX_W = max(1, clog2(NUM_IN))

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
ld_en  input  1  write ld_data into operand register ld_idx this cycle
ld_idx  input  IDX_W  operand register index
ld_data  input  WIDTH  operand value
start  input  1  begin reduction (sampled each edge)
mode  input  2  00 sum, 01 unsigned max, 10 unsigned min, 11 xor
out  output  WIDTH  last completed result, registered
ovf  output  1  sum-mode carry-out seen during last reduction
proc  output  1  reduction in progress
rdy  output  1  result valid

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high.
- Reset (rst=1 at an edge): all operand registers 0, accumulator 0, counter 0, state IDLE, out=0, ovf=0, proc=0, rdy=0. Reset takes priority over every other input, including mid-reduction. An aborted reduction leaves out=0.
- States: IDLE, PROC, DONE. proc=1 only in PROC; rdy=1 only in DONE. Both are decoded from registered state.
- Load:
  - In IDLE or DONE, ld_en=1 writes regs[ld_idx] <= ld_data.
  - ld_idx >= NUM_IN: write ignored.
  - In PROC, ld_en is ignored, so operands stay frozen.
- Start (IDLE or DONE with start=1):
  - Latch mode.
  - acc <= regs[0], cnt <= 1, ovf_acc <= 0.
  - Go to PROC, or directly to DONE when NUM_IN=1.
  - rdy drops on this edge.
- start and ld_en on the same edge: the reduction uses pre-write register values; the write still lands.
- PROC, each edge:
  - acc <= op(acc, regs[cnt]), cnt <= cnt+1.
  - The edge that consumes regs[NUM_IN-1] also loads out/ovf and moves to DONE.
- Latency: counting the start edge as edge 1, rdy=1 after edge NUM_IN. proc is high for exactly NUM_IN-1 cycles.
- out and ovf keep their previous values during PROC and update only on entry to DONE.
- start in PROC is ignored; no restart or queueing.
- DONE holds out/rdy indefinitely until the next start or rst.
- Arithmetic:
  - sum: modulo 2^WIDTH; ovf is the OR of carry-outs of every addition in this reduction.
  - max/min: unsigned compare.
  - xor: bitwise.
  - ovf=0 for modes other than sum.
- A mode change after start has no effect until the next start.

Test Plan:
1. WIDTH=4, NUM_IN=4; load 3,5,2,1 into idx 0..3; start with mode=00 -> proc high 3 cycles, then rdy=1, out=11, ovf=0.
2. Load 9,8,7,6; start with mode=00 -> out=14 (30 mod 16), ovf=1; then rerun with 1,1,1,1 -> out=4, ovf=0.
3. Load 3,12,7,0 and run each mode -> max out=12; min out=0; xor out=8; ovf=0 in all three.
4. During PROC, pulse start and ld_en (idx0=15) -> no restart, out matches the pre-load result; after DONE, idx0 reads 3 in the next sum run.
5. Assert rst on the 2nd PROC cycle -> next edge proc=0, rdy=0, out=0; then start with mode=00 -> out=0 (operands cleared).
6. NUM_IN=3, ld_idx=3 with ld_data=15 -> ignored, sum of 1,2,3 gives 6. NUM_IN=1 with operand 9: start -> rdy after 1 edge, proc never high, out=9.

Source files
------------

// File: rtl/multi_operand_proc.sv
// Operand-reduction processor: NUM_IN indexed operand registers folded into one
// result, one operand per cycle, using sum / unsigned max / unsigned min / xor.
module multi_operand_proc #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4,
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             proc,
  output logic             rdy
);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NUM_IN];
  logic [WIDTH-1:0] regs_d [NUM_IN];
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   step;
  logic             load_ok;

  // Bit WIDTH of the result carries the sum carry-out; it is zero for other modes.
  function automatic logic [WIDTH:0] reduce_op(input logic [1:0] m,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (m)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, (a > b) ? a : b};
      2'b10:   return {1'b0, (a < b) ? a : b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign step    = reduce_op(mode_q, acc_q, regs_q[cnt_q]);
  assign load_ok = ld_en && (state_q != PROC) && (32'(ld_idx) < NUM_IN);

  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    ovf_acc_d = ovf_acc_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    case (state_q)
      PROC: begin
        acc_d     = step[WIDTH-1:0];
        cnt_d     = cnt_q + IDX_W'(1);
        ovf_acc_d = ovf_acc_q | ((mode_q == 2'b00) & step[WIDTH]);
        if (cnt_q == IDX_W'(NUM_IN - 1)) begin
          out_d   = step[WIDTH-1:0];
          ovf_d   = ovf_acc_d;
          state_d = DONE;
        end
      end
      default: begin
        // Start reads regs_q, so a same-edge load lands after the reduction samples.
        if (load_ok) regs_d[ld_idx] = ld_data;
        if (start) begin
          mode_d    = mode;
          acc_d     = regs_q[0];
          cnt_d     = IDX_W'(1);
          ovf_acc_d = 1'b0;
          if (NUM_IN == 1) begin
            out_d   = regs_q[0];
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = PROC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < NUM_IN; i++) regs_q[i] <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 2'b00;
      ovf_acc_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      ovf_acc_q <= ovf_acc_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out  = out_q;
  assign ovf  = ovf_q;
  assign proc = (state_q == PROC);
  assign rdy  = (state_q == DONE);

endmodule
